// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 Laplacian convolution engine.
//
// Raster-order pixels are accepted on a valid/ready handshake. Two line
// buffers and a window register build a 3x3 neighbourhood. Every interior
// pixel produces one signed result on a backpressured output port.
// Optional build macro: CONV_CLAMP_EN clamps each result to [0, 2^PIX_W-1].
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   mode            0 = 4-neighbour kernel, 1 = 8-neighbour kernel; latched
//                   on the first pixel of each frame
//   in_valid/in_ready/in_pix      pixel input stream
//   out_valid/out_ready/out_pix   result stream (signed, OUT_W bits)
//   out_row/out_col               result coordinates (window centre - 1)
//   frame_done      pulse on the handshake of the last result of a frame
//   busy            high from the first accepted pixel until frame_done
module conv3x3_stream #(
    parameter int IMG_W = 10,
    parameter int IMG_H = 10,
    parameter int PIX_W = 8,
    localparam int OUT_W = PIX_W + 4,
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        in_pix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_pix,
    output logic [RW-1:0]           out_row,
    output logic [CW-1:0]           out_col,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int SW = PIX_W + 3;
`ifdef CONV_CLAMP_EN
    localparam logic [OUT_W-1:0] PIX_MAX = OUT_W'((1 << PIX_W) - 1);
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state, state_nx;

    logic [RW-1:0]    in_row;
    logic [CW-1:0]    in_col;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    // Only the two older window columns are stored; the newest column comes
    // straight from the line buffers and in_pix so S1 sees the shifted window
    // in the same cycle the pixel is accepted.
    logic [PIX_W-1:0] win_a [3];
    logic [PIX_W-1:0] win_b [3];
    logic             mode_q;
    logic             next_started;

    logic             stall, accept, first_px, win_ok, last_hs;
    logic [PIX_W-1:0] col_top, col_mid;
    logic [SW-1:0]    sum4, sum8;

    logic             s1_valid, s1_mode;
    logic [SW-1:0]    s1_sum;
    logic [PIX_W-1:0] s1_ctr;
    logic [RW-1:0]    s1_row;
    logic [CW-1:0]    s1_col;
    logic [OUT_W-1:0] ctr_scaled, res_raw, res;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign first_px = (in_row == '0) && (in_col == '0);
    assign win_ok   = (in_row >= RW'(2)) && (in_col >= CW'(2));
    assign last_hs  = out_valid && out_ready &&
                      (out_row == RW'(IMG_H - 3)) && (out_col == CW'(IMG_W - 3));
    assign busy     = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = FILL;
            FILL: if (accept && in_row == RW'(2) && in_col == CW'(2)) state_nx = RUN;
            RUN: begin
                if (last_hs) begin
                    frame_done = 1'b1;
                    // The next frame may already have started while the
                    // previous frame's last results were draining.
                    state_nx = (next_started || (accept && first_px)) ? FILL : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            next_started <= 1'b0;
        end else if (state != RUN || last_hs) begin
            next_started <= 1'b0;
        end else if (accept && first_px) begin
            next_started <= 1'b1;
        end
    end

    // ---------------- input counters and mode latch ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_row <= '0;
            in_col <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (first_px) mode_q <= mode;
            if (in_col == CW'(IMG_W - 1)) begin
                in_col <= '0;
                in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + RW'(1);
            end else begin
                in_col <= in_col + CW'(1);
            end
        end
    end

    // ---------------- line buffers and window ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= in_pix;
            win_a[0]    <= win_b[0];
            win_a[1]    <= win_b[1];
            win_a[2]    <= win_b[2];
            win_b[0]    <= col_top;
            win_b[1]    <= col_mid;
            win_b[2]    <= in_pix;
        end
    end

    // Window after the shift: left = win_a, centre = win_b, right = new column.
    always_comb begin
        col_top = lb1[in_col];
        col_mid = lb0[in_col];
        sum4 = SW'(win_b[0]) + SW'(win_b[2]) + SW'(win_a[1]) + SW'(col_mid);
        sum8 = SW'(win_a[0]) + SW'(win_a[1]) + SW'(win_a[2]) +
               SW'(win_b[0]) + SW'(win_b[2]) +
               SW'(col_top) + SW'(col_mid) + SW'(in_pix);
    end

    // ---------------- S1: neighbour sum ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_sum   <= '0;
            s1_ctr   <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else if (!stall) begin
            s1_valid <= accept && win_ok;
            s1_mode  <= mode_q;
            s1_sum   <= mode_q ? sum8 : sum4;
            s1_ctr   <= win_b[1];
            s1_row   <= in_row - RW'(2);
            s1_col   <= in_col - CW'(2);
        end
    end

    // ---------------- S2: centre weighting ----------------
    always_comb begin
        ctr_scaled = s1_mode ? (OUT_W'(s1_ctr) << 3) : (OUT_W'(s1_ctr) << 2);
        res_raw    = OUT_W'(s1_sum) - ctr_scaled;
`ifdef CONV_CLAMP_EN
        if (res_raw[OUT_W-1])      res = '0;
        else if (res_raw > PIX_MAX) res = PIX_MAX;
        else                        res = res_raw;
`else
        res = res_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pix <= res;
                out_row <= s1_row;
                out_col <= s1_col;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: frame-level reference model,
// randomized gaps/backpressure, per-cycle output comparison.
module tb_conv3x3_stream;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int P  = 8;
    localparam int OW = P + 4;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, mode, in_valid, in_ready, out_valid, out_ready;
    logic [P-1:0]         in_pix;
    logic signed [OW-1:0] out_pix;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic                 frame_done, busy;

    conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done), .busy(busy)
    );

    typedef struct {
        int pix;
        int row;
        int col;
        bit last;
    } exp_t;

    exp_t expq[$];
    int   accq[$];
    int   img[H][W];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   stall_req = 1'b0;
    bit   lat_chk = 1'b0;
    int   hs_cnt = 0;
    int   stall_seen = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: Laplacian of the frame centred at (r,c), from the kernel definition.
    function automatic int model_val(input int r, input int c, input bit m);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && (m || dr == 0 || dc == 0))
                    s += img[r+dr][c+dc];
        s -= (m ? 8 : 4) * img[r][c];
`ifdef CONV_CLAMP_EN
        if (s < 0) s = 0;
        if (s > (1 << P) - 1) s = (1 << P) - 1;
`endif
        return s;
    endfunction

    // Queue the results a frame must produce; abort_at < 0 means the whole frame.
    function automatic int push_exp(input bit m, input int abort_at);
        int n = 0;
        exp_t e;
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++) begin
                if (abort_at >= 0 && r * W + c >= abort_at) continue;
                e.pix  = model_val(r - 1, c - 1, m);
                e.row  = r - 2;
                e.col  = c - 2;
                e.last = (abort_at < 0) && (r == H - 1) && (c == W - 1);
                expq.push_back(e);
                n++;
            end
        return n;
    endfunction

    task automatic fill_img(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (kind == 2) ? int'($urandom_range(255)) : val;
    endtask

    // Drives one frame; mode is toggled randomly after the first pixel.
    task automatic send_frame(input bit m, input int gap_pct, input int abort_at,
                              input int stall_pix);
        bit acc;
        int cnt;
        mode = m;
        for (int idx = 0; idx < W * H; idx++) begin
            if (abort_at >= 0 && idx == abort_at) break;
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_pix   = P'(img[idx / W][idx % W]);
            if (idx == stall_pix) stall_req = 1'b1;
            acc = 1'b0;
            cnt = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                cnt++;
                if (cnt > 1000) begin
                    $display("FAIL in_ready_timeout actual=0 required=1");
                    $fatal(1, "input stalled");
                end
            end
            mode = 1'($urandom_range(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit expect_idle);
        int n = 0;
        in_valid = 1'b0;
        while (expq.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", expq.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        if (expect_idle) chk("busy_after_frame", busy, 0);
    endtask

    // Output readiness: 0 = always ready, 1 = random; stall_req forces 5 low cycles.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (stall_req) begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2;
                out_ready = 1'b1;
                stall_req = 1'b0;
            end else begin
                out_ready = (rdy_mode == 0) ? 1'b1 : (int'($urandom_range(99)) < 70);
            end
        end
    end

    // Per-cycle compare against the reference queues.
    bit                   prev_stall = 1'b0;
    logic signed [OW-1:0] prev_pix;
    logic [RW-1:0]        prev_row;
    logic [CW-1:0]        prev_col;
    int                   mrow = 0, mcol = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            mrow = 0;
            mcol = 0;
            accq.delete();
        end else begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_pix_hold", out_pix, prev_pix);
                chk("stall_row_hold", out_row, prev_row);
                chk("stall_col_hold", out_col, prev_col);
            end
            if (in_valid && in_ready) begin
                if (mrow >= 2 && mcol >= 2) accq.push_back(cyc);
                if (mcol == W - 1) begin
                    mcol = 0;
                    mrow = (mrow == H - 1) ? 0 : mrow + 1;
                end else mcol++;
            end
            if (out_valid && out_ready) begin
                exp_t e;
                int   a;
                hs_cnt++;
                chk("busy_on_result", busy, 1);
                if (expq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_pix", out_pix, e.pix);
                    chk("out_row", out_row, e.row);
                    chk("out_col", out_col, e.col);
                    chk("frame_done", frame_done, e.last);
                end
                if (accq.size() > 0) begin
                    a = accq.pop_front();
                    if (lat_chk) chk("latency", cyc - a, 2);
                end
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            if (out_valid && !out_ready) stall_seen++;
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pix;
            prev_row   = out_row;
            prev_col   = out_col;
        end
    end

    initial begin
        int n;
        reset = 1'b0; mode = 1'b0; in_valid = 1'b0; in_pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Flat frame, mode 0, no gaps, always ready: 64 zeros, latency 2.
        fill_img(0, 100);
        rdy_mode = 0; lat_chk = 1'b1; hs_cnt = 0;
        n = push_exp(1'b0, -1);
        chk("model_count", n, 64);
        chk("model_flat", model_val(4, 4, 1'b0), 0);
        send_frame(1'b0, 0, -1, -1);
        drain(1'b1);
        chk("result_count", hs_cnt, 64);

        // Impulse, mode 0, random input gaps.
        fill_img(0, 0);
        img[4][4] = 255;
`ifdef CONV_CLAMP_EN
        chk("model_imp_m0_centre", model_val(4, 4, 1'b0), 0);
`else
        chk("model_imp_m0_centre", model_val(4, 4, 1'b0), -1020);
`endif
        chk("model_imp_m0_north", model_val(3, 4, 1'b0), 255);
        chk("model_imp_m0_diag", model_val(3, 3, 1'b0), 0);
        void'(push_exp(1'b0, -1));
        send_frame(1'b0, 30, -1, -1);
        drain(1'b1);

        // Impulse, mode 1.
`ifdef CONV_CLAMP_EN
        chk("model_imp_m1_centre", model_val(4, 4, 1'b1), 0);
`else
        chk("model_imp_m1_centre", model_val(4, 4, 1'b1), -2040);
`endif
        chk("model_imp_m1_diag", model_val(3, 3, 1'b1), 255);
        void'(push_exp(1'b1, -1));
        send_frame(1'b1, 30, -1, -1);
        drain(1'b1);

        // Random frame, random gaps and backpressure.
        lat_chk = 1'b0;
        rdy_mode = 1;
        fill_img(2, 0);
        void'(push_exp(1'b1, -1));
        send_frame(1'b1, 20, -1, -1);
        drain(1'b1);

        // Random frame with a forced 5-cycle output stall mid-frame.
        rdy_mode = 0;
        stall_seen = 0;
        fill_img(2, 0);
        void'(push_exp(1'b0, -1));
        send_frame(1'b0, 0, -1, 44);
        drain(1'b1);
        chk("stall_observed", stall_seen > 0, 1);

        // Abort at pixel 37, then a fresh all-50 frame in mode 1.
        fill_img(2, 0);
        void'(push_exp(1'b0, 37));
        send_frame(1'b0, 0, 37, -1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_drained", expq.size(), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_after_abort", busy, 0);
        chk("out_valid_after_abort", out_valid, 0);
        @(posedge clk); #1;
        lat_chk = 1'b1;
        hs_cnt = 0;
        fill_img(0, 50);
        void'(push_exp(1'b1, -1));
        send_frame(1'b1, 0, -1, -1);
        drain(1'b1);
        chk("result_count_after_abort", hs_cnt, 64);

        // Back-to-back frames: next frame starts while the last results drain.
        lat_chk = 1'b0;
        rdy_mode = 1;
        fill_img(2, 0);
        void'(push_exp(1'b0, -1));
        send_frame(1'b0, 0, -1, -1);
        fill_img(2, 0);
        void'(push_exp(1'b1, -1));
        send_frame(1'b1, 0, -1, -1);
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3x3 convolution engine, the successor to the fixed 10x10, 4-neighbour Laplacian pipeline. Raster-order pixels enter through a valid/ready handshake and are held in two on-chip line buffers instead of a full-frame memory. For every interior pixel the block emits one signed result, with centre coordinates, through a backpressured output port. A run-time mode selects a 4-neighbour or 8-neighbour Laplacian kernel. The block sits between the pixel source and the downstream accumulator/writeback stage.

## Interface
- IMG_W, 10, image width in pixels (>=3)
- IMG_H, 10, image height in pixels (>=3)
- PIX_W, 8, unsigned input pixel width
- OUT_W (localparam), PIX_W+4, signed result width; covers ±8·(2^PIX_W−1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- mode  in  1  kernel select: 0 = 4-neighbour (centre −4, N/S/E/W +1); 1 = 8-neighbour (centre −8, all 8 neighbours +1); sampled on the first accepted pixel of a frame
- in_valid  in  1  in_pix is valid
- in_ready  out  1  block accepts in_pix this cycle
- in_pix  in  PIX_W  input pixel, raster order, row 0 col 0 first
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_pix  out  OUT_W  signed convolution result
- out_row  out  $clog2(IMG_H)  result row index, 0..IMG_H−3 (window centre row − 1)
- out_col  out  $clog2(IMG_W)  result column index, 0..IMG_W−3
- frame_done  out  1  one-cycle pulse on the handshake of the last result of a frame
- busy  out  1  high from the first accepted pixel until frame_done

## Operation
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Counters in_row/in_col track accepted pixels. in_col wraps at IMG_W−1 and increments in_row. Both clear after pixel (IMG_H−1, IMG_W−1).
- Line buffers: two IMG_W×PIX_W rows plus a 3x3 window shift register. On each accepted pixel the window shifts left, the new column {lb1[col], lb0[col], in_pix} enters on the right, lb1[col]←lb0[col], and lb0[col]←in_pix.
- A window is valid when the accepted pixel has in_row>=2 and in_col>=2. Windows that wrap across a row boundary are never valid.
- FSM states:
  - IDLE: first accepted pixel → FILL; latches mode, sets busy.
  - FILL: acceptance of pixel (2,2) → RUN.
  - RUN: handshake of result (IMG_H−3, IMG_W−3) → IDLE; pulses frame_done, clears busy.
- Pipeline:
  - S1 registers the window sum: 4-neighbour sum, or 8-neighbour sum.
  - S2 computes centre·(−4 or −8) + S1 sum into out_pix, and also registers out_row/out_col.
  - Arithmetic is fully signed in OUT_W bits and never overflows.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled every pipeline register, counter and line buffer holds. Bubbles (invalid windows) propagate as valid=0 and never reach out_valid.
- mode changes mid-frame are ignored until the next IDLE→FILL transition.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is row 0 col 0.
- Reset values: in_ready 1, out_valid 0, out_pix 0, out_row 0, out_col 0, frame_done 0, busy 0, FSM IDLE, all counters 0. Line buffer contents are don't-care.

## Timing
- Latency: pixel accepted in cycle t that completes a valid window → out_valid in cycle t+2, absent stall.
- First result follows the (2·IMG_W+3)-th accepted pixel. A 10x10 frame yields 64 results.
- Sustained throughput is 1 pixel/cycle with in_valid and out_ready held high.
- in_ready is combinational from out_valid/out_ready only, never from in_valid.
- out_pix, out_row and out_col are stable while out_valid && !out_ready.
- frame_done is asserted in the same cycle as the final output handshake.
- In-frame gaps (in_valid low) insert bubbles and never corrupt window alignment.

## Configuration
- CONV_CLAMP_EN defined: the S2 result is clamped to [0, 2^PIX_W−1] and zero-extended to OUT_W. This adds one comparator stage in S2 with no extra latency.
- CONV_CLAMP_EN undefined: out_pix is the raw signed result.

## Test plan
- 10x10 frame, all pixels 100, mode 0, out_ready=1 → 64 results, all 0. Coordinates run (0,0)..(7,7) in raster order. First out_valid 2 cycles after the 23rd accepted pixel. frame_done on the 64th.
- 10x10 frame, zeros except (4,4)=255, mode 0 → result (3,3)=−1020; (2,3),(4,3),(3,2),(3,4)=255; all others 0. Same frame with mode 1 → (3,3)=−2040, and all 8 neighbours of (3,3)=255.
- Same impulse with CONV_CLAMP_EN, mode 1 → (3,3)=0, neighbours 255.
- Stream under random in_valid gaps and out_ready held low for 5 cycles mid-frame → in_ready low during the stall, out_pix/out_row/out_col stable, result sequence identical to the no-stall run.
- reset driven low at pixel 37 of a frame, then a fresh all-50 frame with mode 1 → no results from the aborted frame, 64 zeros, busy low until the first new pixel.
- mode toggled during a frame → results use the mode latched at that frame's first pixel.
